// File: rtl/vram_port_arbiter_pkg.sv
// Shared VRAM geometry, widths and fill-engine state type for the VRAM write-port arbiter.
package vram_port_arbiter_pkg;

    localparam int unsigned H_RES  = 160;
    localparam int unsigned V_RES  = 120;
    localparam int unsigned ADDR_W = 15;
    localparam int unsigned DATA_W = 8;

    typedef enum logic [1:0] {
        FILL_IDLE  = 2'd0,
        FILL_SETUP = 2'd1,
        FILL_RUN   = 2'd2,
        FILL_DONE  = 2'd3
    } fill_state_t;

    // y*160 + x as (y<<7) + (y<<5) + x, so no multiplier is inferred
    function automatic logic [ADDR_W-1:0] row_base(input logic [6:0] y, input logic [7:0] x);
        logic [ADDR_W-1:0] yw;
        yw = {8'b0, y};
        return (yw << 7) + (yw << 5) + {7'b0, x};
    endfunction

endpackage

// File: rtl/vram_port_arbiter_fill_engine.sv
// Rectangle-fill engine: latches a command, clips it to the screen and walks the
// clipped area row by row, requesting one VRAM write per granted cycle.
module vram_port_arbiter_fill_engine
    import vram_port_arbiter_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              fill_start,
    input  logic [7:0]        fill_x0,
    input  logic [6:0]        fill_y0,
    input  logic [7:0]        fill_w,
    input  logic [6:0]        fill_h,
    input  logic [DATA_W-1:0] fill_color,
    input  logic              fill_abort,
    input  logic              gnt,
    output logic              req,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data,
    output logic              run,
    output logic              fill_busy,
    output logic              fill_done
);

    fill_state_t       state_q, state_d;
    logic [7:0]        x0_q, x0_d, w_q, w_d, w_eff_q, w_eff_d, col_q, col_d;
    logic [6:0]        y0_q, y0_d, h_q, h_d, h_eff_q, h_eff_d, row_q, row_d;
    logic [DATA_W-1:0] color_q, color_d;
    logic [ADDR_W-1:0] base_q, base_d, ptr_q, ptr_d;

    logic [7:0] w_lim;
    logic [6:0] h_lim;
    logic       empty;

    // Clipping of the latched operands, only meaningful in SETUP
    always_comb begin
        w_lim = 8'(H_RES) - x0_q;
        h_lim = 7'(V_RES) - y0_q;
        empty = (x0_q >= 8'(H_RES)) || (y0_q >= 7'(V_RES)) || (w_q == 8'd0) || (h_q == 7'd0);
    end

    // Next-state, operand latch and address walk
    always_comb begin
        state_d = state_q;
        x0_d    = x0_q;
        y0_d    = y0_q;
        w_d     = w_q;
        h_d     = h_q;
        color_d = color_q;
        w_eff_d = w_eff_q;
        h_eff_d = h_eff_q;
        col_d   = col_q;
        row_d   = row_q;
        base_d  = base_q;
        ptr_d   = ptr_q;
        case (state_q)
            FILL_IDLE: begin
                if (fill_start && !fill_abort) begin
                    x0_d    = fill_x0;
                    y0_d    = fill_y0;
                    w_d     = fill_w;
                    h_d     = fill_h;
                    color_d = fill_color;
                    state_d = FILL_SETUP;
                end
            end
            FILL_SETUP: begin
                if (fill_abort) begin
                    state_d = FILL_IDLE;
                end else begin
                    w_eff_d = (w_q < w_lim) ? w_q : w_lim;
                    h_eff_d = (h_q < h_lim) ? h_q : h_lim;
                    base_d  = row_base(y0_q, x0_q);
                    ptr_d   = row_base(y0_q, x0_q);
                    col_d   = '0;
                    row_d   = '0;
                    state_d = empty ? FILL_DONE : FILL_RUN;
                end
            end
            FILL_RUN: begin
                if (fill_abort) begin
                    state_d = FILL_IDLE;
                end else if (gnt) begin
                    if (col_q == w_eff_q - 8'd1) begin
                        if (row_q == h_eff_q - 7'd1) begin
                            state_d = FILL_DONE;
                        end else begin
                            base_d = base_q + ADDR_W'(H_RES);
                            ptr_d  = base_q + ADDR_W'(H_RES);
                            col_d  = '0;
                            row_d  = row_q + 7'd1;
                        end
                    end else begin
                        ptr_d = ptr_q + 15'd1;
                        col_d = col_q + 8'd1;
                    end
                end
            end
            default: state_d = FILL_IDLE;
        endcase
    end

    // State and operand registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FILL_IDLE;
            x0_q    <= '0;
            y0_q    <= '0;
            w_q     <= '0;
            h_q     <= '0;
            color_q <= '0;
            w_eff_q <= '0;
            h_eff_q <= '0;
            col_q   <= '0;
            row_q   <= '0;
            base_q  <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            x0_q    <= x0_d;
            y0_q    <= y0_d;
            w_q     <= w_d;
            h_q     <= h_d;
            color_q <= color_d;
            w_eff_q <= w_eff_d;
            h_eff_q <= h_eff_d;
            col_q   <= col_d;
            row_q   <= row_d;
            base_q  <= base_d;
            ptr_q   <= ptr_d;
        end
    end

    // Abort suppresses the request so the abort cycle itself writes nothing
    always_comb begin
        run       = (state_q == FILL_RUN);
        req       = (state_q == FILL_RUN) && !fill_abort;
        addr      = ptr_q;
        data      = color_q;
        fill_busy = (state_q == FILL_SETUP) || (state_q == FILL_RUN);
        fill_done = (state_q == FILL_DONE);
    end

endmodule

// File: rtl/vram_port_arbiter.sv
// VRAM_B port-A owner: arbitrates CPU stores against the fill engine with CPU
// priority and a burst limit, and registers the winning write toward the RAM.
module vram_port_arbiter
    import vram_port_arbiter_pkg::*;
#(
    parameter int unsigned CPU_BURST_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_data,
    output logic              cpu_ready,
    input  logic              fill_start,
    input  logic [7:0]        fill_x0,
    input  logic [6:0]        fill_y0,
    input  logic [7:0]        fill_w,
    input  logic [6:0]        fill_h,
    input  logic [DATA_W-1:0] fill_color,
    input  logic              fill_abort,
    output logic              fill_busy,
    output logic              fill_done,
    output logic [ADDR_W-1:0] vram_addr,
    output logic [DATA_W-1:0] vram_din,
    output logic              vram_we
);

    logic              eng_req, eng_gnt, eng_run, cpu_gnt;
    logic [ADDR_W-1:0] eng_addr;
    logic [DATA_W-1:0] eng_data;

    logic [3:0]        burst_q, burst_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] din_q, din_d;

    vram_port_arbiter_fill_engine u_fill (
        .clk        (clk),
        .rst        (rst),
        .fill_start (fill_start),
        .fill_x0    (fill_x0),
        .fill_y0    (fill_y0),
        .fill_w     (fill_w),
        .fill_h     (fill_h),
        .fill_color (fill_color),
        .fill_abort (fill_abort),
        .gnt        (eng_gnt),
        .req        (eng_req),
        .addr       (eng_addr),
        .data       (eng_data),
        .run        (eng_run),
        .fill_busy  (fill_busy),
        .fill_done  (fill_done)
    );

    // Grant selection, burst counting and next write-port values
    always_comb begin
        cpu_ready = !(eng_run && (burst_q == 4'(CPU_BURST_MAX)));
        cpu_gnt   = cpu_we && cpu_ready;
        eng_gnt   = eng_req && !cpu_gnt;
        burst_d   = '0;
        if (eng_run && cpu_gnt) begin
            burst_d = burst_q + 4'd1;
        end
        we_d   = cpu_gnt || eng_gnt;
        addr_d = addr_q;
        din_d  = din_q;
        if (cpu_gnt) begin
            addr_d = cpu_addr;
            din_d  = cpu_data;
        end else if (eng_gnt) begin
            addr_d = eng_addr;
            din_d  = eng_data;
        end
    end

    // Burst counter and registered VRAM port
    always_ff @(posedge clk) begin
        if (rst) begin
            burst_q <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            din_q   <= '0;
        end else begin
            burst_q <= burst_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
        end
    end

    assign vram_we   = we_q;
    assign vram_addr = addr_q;
    assign vram_din  = din_q;

endmodule
